ram_autoconfig_multi: RTL and testbench

//  Parametrised Zorro II autoconfig fast-RAM controller: presents BANKS chained autoconfig boards at $E80000.

---
 rtl/ram_autoconfig_multi.sv | 179 +++++++++++++++++
 tb/tb_ram_autoconfig_multi.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_autoconfig_multi.sv
// rtl/ram_autoconfig_multi.sv - Zorro II autoconfig fast-RAM controller with chained banks
//
// Presents BANKS autoconfig RAM boards at $E80000, one at a time, latches each
// board's base address and decodes CPU cycles to per-bank RAM chip enables with
// a programmable DTACK wait.
//
// Optional feature macro: RAM_AC_SHUTUP_EN (a write to $4C shuts up the active bank).
//
// Ports:
//   CLK          in   CPU clock, all state on rising edge
//   _RESET       in   synchronous active-low reset
//   _AS,_UDS,_LDS,R_W in 68000 bus strobes
//   AH[7:0]      in   A[23:16]
//   AL[5:0]      in   A[6:1], autoconfig register offset
//   D_IN[3:0]    in   D[15:12] for config writes
//   D_OUT[3:0]   out  D[15:12] read nibble (registered)
//   D_OE         out  drive D_OUT onto the bus (registered)
//   _CONFIGIN    in   autoconfig chain in, low = our turn
//   _CONFIGOUT   out  chain out, low = every bank configured or shut up
//   DTACK_REQ    out  request the top level to drive _DTACK low (registered)
//   RAMCE        out  per-bank RAM chip enable, active high
//   CONFIGURED   out  per-bank configured flag
module ram_autoconfig_multi #(
  parameter int          BANKS       = 2,
  parameter logic [2:0]  SIZE_CODE   = 3'b110,
  parameter logic [15:0] MANUF_ID    = 16'h07DB,
  parameter logic [7:0]  PROD_ID     = 8'h11,
  parameter int          WAIT_STATES = 0
) (
  input  logic             CLK,
  input  logic             _RESET,
  input  logic             _AS,
  input  logic             _UDS,
  input  logic             _LDS,
  input  logic             R_W,
  input  logic [7:0]       AH,
  input  logic [5:0]       AL,
  input  logic [3:0]       D_IN,
  output logic [3:0]       D_OUT,
  output logic             D_OE,
  input  logic             _CONFIGIN,
  output logic             _CONFIGOUT,
  output logic             DTACK_REQ,
  output logic [BANKS-1:0] RAMCE,
  output logic [BANKS-1:0] CONFIGURED
);

  typedef enum logic [1:0] {UNCONF = 2'd0, CONF = 2'd1, SHUTUP = 2'd2} bank_state_t;

  localparam logic [5:0] REG_BASE_HI = 6'h24;  // $48
  localparam logic [5:0] REG_BASE_LO = 6'h25;  // $4A
  localparam logic [5:0] REG_SHUTUP  = 6'h26;  // $4C

  // Address bits compared against the base: board size keeps the low bits free.
  localparam logic [7:0] MASK = (SIZE_CODE == 3'b101) ? 8'hF0 :
                                (SIZE_CODE == 3'b111) ? 8'hC0 : 8'hE0;

  bank_state_t st   [BANKS];
  logic [7:0]  base [BANKS];   // base[23:16]
  logic        busy;           // a config write was already taken this bus cycle
  logic        cyc;            // DTACK counting active for this bus cycle
  logic [1:0]  cnt;

  logic        all_done;
  logic [1:0]  cur;
  logic        cfg_hit;
  logic        cfg_wr;
  logic        bank_any;
  logic [7:0]  prod;
  logic [3:0]  rom;

  // Active bank is the lowest index still unconfigured.
  always_comb begin
    cur      = 2'd0;
    all_done = 1'b1;
    for (int i = BANKS - 1; i >= 0; i--) begin
      if (st[i] == UNCONF) begin
        cur      = 2'(i);
        all_done = 1'b0;
      end
    end
  end

  assign _CONFIGOUT = ~all_done;
  assign cfg_hit    = (AH == 8'hE8) & ~_CONFIGIN & _CONFIGOUT & ~_AS;
  assign cfg_wr     = cfg_hit & ~R_W & ~_UDS & ~busy;
  assign prod       = PROD_ID + 8'(cur);

  // Autoconfig nibble ROM; $00/$02 read true, the rest inverted.
  always_comb begin
    case (AL)
      6'h00:   rom = 4'hE;
      6'h01:   rom = {1'b0, SIZE_CODE};
      6'h02:   rom = ~prod[7:4];
      6'h03:   rom = ~prod[3:0];
      6'h04:   rom = ~4'h0;
      6'h08:   rom = ~MANUF_ID[15:12];
      6'h09:   rom = ~MANUF_ID[11:8];
      6'h0A:   rom = ~MANUF_ID[7:4];
      6'h0B:   rom = ~MANUF_ID[3:0];
      default: rom = 4'hF;
    endcase
  end

  // Address decode; with overlapping bases the lowest index takes the cycle.
  always_comb begin
    RAMCE      = '0;
    CONFIGURED = '0;
    bank_any   = 1'b0;
    for (int i = 0; i < BANKS; i++) begin
      CONFIGURED[i] = (st[i] == CONF);
      if ((st[i] == CONF) && (((AH ^ base[i]) & MASK) == 8'h00) && !bank_any) begin
        RAMCE[i] = ~_AS & (~_UDS | ~_LDS);
        bank_any = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      for (int i = 0; i < BANKS; i++) begin
        st[i]   <= UNCONF;
        base[i] <= 8'h00;
      end
      busy      <= 1'b0;
      D_OE      <= 1'b0;
      D_OUT     <= 4'h0;
      DTACK_REQ <= 1'b0;
      cyc       <= 1'b0;
      cnt       <= 2'd0;
    end else begin
      if (_AS)
        busy <= 1'b0;
      else if (cfg_hit && !R_W && !_UDS)
        busy <= 1'b1;

      for (int i = 0; i < BANKS; i++) begin
        if (cfg_wr && (2'(i) == cur)) begin
          if (AL == REG_BASE_LO)
            base[i][3:0] <= D_IN;
          if (AL == REG_BASE_HI) begin
            base[i][7:4] <= D_IN;
            st[i]        <= CONF;
          end
`ifdef RAM_AC_SHUTUP_EN
          if (AL == REG_SHUTUP)
            st[i] <= SHUTUP;
`endif
        end
      end

      if (_AS)
        D_OE <= 1'b0;
      else if (cfg_hit && R_W) begin
        D_OE  <= 1'b1;
        D_OUT <= rom;
      end

      // cnt holds the number of edges already seen, so the first edge counts as 0.
      if (_AS) begin
        cyc       <= 1'b0;
        cnt       <= 2'd0;
        DTACK_REQ <= 1'b0;
      end else if (!cyc) begin
        if (cfg_hit || bank_any) begin
          cyc       <= 1'b1;
          cnt       <= 2'd1;
          DTACK_REQ <= (WAIT_STATES == 0);
        end
      end else begin
        if (cnt == 2'(WAIT_STATES))
          DTACK_REQ <= 1'b1;
        if (cnt != 2'd3)
          cnt <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_ram_autoconfig_multi.sv
// tb/tb_ram_autoconfig_multi.sv - self-checking bench for ram_autoconfig_multi
module tb_ram_autoconfig_multi;

  logic       clk = 1'b0;
  logic       reset_n, as_n, uds_n, lds_n, r_w, configin_n;
  logic [7:0] ah;
  logic [5:0] al;
  logic [3:0] d_in;

  logic [3:0] d_out, d_out_w;
  logic       d_oe, d_oe_w, configout_n, configout_w, dtack_req, dtack_w;
  logic [1:0] ramce, ramce_w, configured, configured_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_autoconfig_multi dut (
    .CLK(clk), ._RESET(reset_n), ._AS(as_n), ._UDS(uds_n), ._LDS(lds_n), .R_W(r_w),
    .AH(ah), .AL(al), .D_IN(d_in), .D_OUT(d_out), .D_OE(d_oe),
    ._CONFIGIN(configin_n), ._CONFIGOUT(configout_n), .DTACK_REQ(dtack_req),
    .RAMCE(ramce), .CONFIGURED(configured)
  );

  ram_autoconfig_multi #(.WAIT_STATES(2)) dut_w (
    .CLK(clk), ._RESET(reset_n), ._AS(as_n), ._UDS(uds_n), ._LDS(lds_n), .R_W(r_w),
    .AH(ah), .AL(al), .D_IN(d_in), .D_OUT(d_out_w), .D_OE(d_oe_w),
    ._CONFIGIN(configin_n), ._CONFIGOUT(configout_w), .DTACK_REQ(dtack_w),
    .RAMCE(ramce_w), .CONFIGURED(configured_w)
  );

  typedef struct {
    logic [5:0] al;
    logic [3:0] exp;
  } rd_vec_t;

  rd_vec_t rom_tab[11];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; r_w = 1'b1;
  endtask

  task automatic do_reset;
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic cfg_read(input logic [5:0] a, input logic [3:0] exp, input string nm);
    ah = 8'hE8; al = a; r_w = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    tick();
    chk({nm, "_doe"}, d_oe, 1'b1);
    chk({nm, "_dout"}, d_out, exp);
    chk({nm, "_dtack"}, dtack_req, 1'b1);
    idle();
    tick();
    chk({nm, "_doe_off"}, d_oe, 1'b0);
    chk({nm, "_dtack_off"}, dtack_req, 1'b0);
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [3:0] d, input int edges);
    ah = 8'hE8; al = a; d_in = d; r_w = 1'b0; uds_n = 1'b0; lds_n = 1'b1; as_n = 1'b0;
    repeat (edges) tick();
    idle();
    tick();
  endtask

  task automatic ram_access(input logic [7:0] a, input logic u, input logic l,
                            input logic [1:0] exp_ce, input logic exp_dt, input string nm);
    ah = a; al = 6'h00; r_w = 1'b1; uds_n = u; lds_n = l; as_n = 1'b0;
    #1;
    chk({nm, "_ramce"}, ramce, exp_ce);
    tick();
    chk({nm, "_ramce_hold"}, ramce, exp_ce);
    chk({nm, "_dtack"}, dtack_req, exp_dt);
    chk({nm, "_doe"}, d_oe, 1'b0);
    idle();
    tick();
    chk({nm, "_dtack_off"}, dtack_req, 1'b0);
  endtask

  // Reference decode: 2MB boards occupy [base, base + 2MB) in the 24-bit space.
  function automatic logic [1:0] model_sel(input int a_hi, input int b0, input int b1);
    int a, lo0, lo1;
    a   = a_hi << 16;
    lo0 = b0 << 20;
    lo1 = b1 << 20;
    if (a >= lo0 && a < lo0 + (1 << 21)) return 2'b01;
    if (a >= lo1 && a < lo1 + (1 << 21)) return 2'b10;
    return 2'b00;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rom_tab[0]  = '{6'h00, 4'hE};
    rom_tab[1]  = '{6'h01, 4'h6};
    rom_tab[2]  = '{6'h02, 4'hE};
    rom_tab[3]  = '{6'h03, 4'hE};
    rom_tab[4]  = '{6'h04, 4'hF};
    rom_tab[5]  = '{6'h08, 4'hF};
    rom_tab[6]  = '{6'h09, 4'h8};
    rom_tab[7]  = '{6'h0A, 4'h2};
    rom_tab[8]  = '{6'h0B, 4'h4};
    rom_tab[9]  = '{6'h06, 4'hF};
    rom_tab[10] = '{6'h10, 4'hF};

    ah = 8'h00; al = 6'h00; d_in = 4'h0; configin_n = 1'b0;
    do_reset();

    chk("rst_configured", configured, 2'b00);
    chk("rst_configout", configout_n, 1'b1);
    chk("rst_doe", d_oe, 1'b0);
    chk("rst_dtack", dtack_req, 1'b0);
    chk("rst_ramce", ramce, 2'b00);

    // Chain input high: not our turn, config space stays silent.
    configin_n = 1'b1;
    ah = 8'hE8; al = 6'h00; r_w = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    tick();
    chk("cfgin_high_doe", d_oe, 1'b0);
    chk("cfgin_high_dtack", dtack_req, 1'b0);
    idle();
    tick();
    configin_n = 1'b0;

    for (int i = 0; i < 11; i++)
      cfg_read(rom_tab[i].al, rom_tab[i].exp, $sformatf("rom%0d", i));

    // A write strobed only on _LDS is not a config write.
    ah = 8'hE8; al = 6'h24; d_in = 4'h2; r_w = 1'b0; uds_n = 1'b1; lds_n = 1'b0; as_n = 1'b0;
    tick();
    idle();
    tick();
    chk("lds_write_ignored", configured, 2'b00);

`ifdef RAM_AC_SHUTUP_EN
    cfg_write(6'h26, 4'h0, 1);
    chk("shut_configured", configured, 2'b00);
    chk("shut_configout", configout_n, 1'b1);
    cfg_read(6'h03, 4'hD, "shut_b1_prod_lo");
    cfg_write(6'h24, 4'h4, 1);
    chk("shut_configout_done", configout_n, 1'b0);
    ram_access(8'h20, 1'b0, 1'b1, 2'b00, 1'b0, "shut_bank0");
    do_reset();
`else
    cfg_write(6'h26, 4'h0, 1);
    chk("shut_ignored_configured", configured, 2'b00);
    chk("shut_ignored_configout", configout_n, 1'b1);
    cfg_read(6'h03, 4'hE, "shut_ignored_b0_prod");
`endif

    // $48 held for three edges: only the first edge may take effect.
    cfg_write(6'h25, 4'h0, 1);
    cfg_write(6'h24, 4'h2, 3);
    chk("b0_configured", configured, 2'b01);
    chk("b0_configout", configout_n, 1'b1);
    chk("b0_configured_w", configured_w, 2'b01);

    cfg_read(6'h02, 4'hE, "b1_prod_hi");
    cfg_read(6'h03, 4'hD, "b1_prod_lo");

    cfg_write(6'h25, 4'h0, 1);
    cfg_write(6'h24, 4'h4, 1);
    chk("b1_configured", configured, 2'b11);
    chk("b1_configout", configout_n, 1'b0);

    // Config space ignored once the chain is done.
    ah = 8'hE8; al = 6'h00; r_w = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    tick();
    chk("done_cfg_doe", d_oe, 1'b0);
    chk("done_cfg_dtack", dtack_req, 1'b0);
    idle();
    tick();

    ram_access(8'h2F, 1'b0, 1'b1, 2'b01, 1'b1, "ram_2ffffe");
    ram_access(8'h40, 1'b1, 1'b0, 2'b10, 1'b1, "ram_400000");
    ram_access(8'h60, 1'b0, 1'b0, 2'b00, 1'b0, "ram_600000");
    ram_access(8'h21, 1'b1, 1'b1, 2'b00, 1'b1, "ram_no_strobe");

    // Wait-state instance: DTACK on the 3rd edge, dropped the edge after _AS rises.
    ah = 8'h40; uds_n = 1'b0; r_w = 1'b1; as_n = 1'b0;
    tick();
    chk("ws0_edge1", dtack_req, 1'b1);
    chk("ws2_edge1", dtack_w, 1'b0);
    tick();
    chk("ws2_edge2", dtack_w, 1'b0);
    tick();
    chk("ws2_edge3", dtack_w, 1'b1);
    tick();
    chk("ws2_edge4", dtack_w, 1'b1);
    idle();
    tick();
    chk("ws2_release", dtack_w, 1'b0);
    chk("ws0_release", dtack_req, 1'b0);

    // Reset in the middle of a RAM cycle.
    ah = 8'h20; uds_n = 1'b0; r_w = 1'b1; as_n = 1'b0;
    tick();
    chk("midrst_pre_dtack", dtack_req, 1'b1);
    reset_n = 1'b0;
    tick();
    chk("midrst_ramce", ramce, 2'b00);
    chk("midrst_dtack", dtack_req, 1'b0);
    chk("midrst_configured", configured, 2'b00);
    chk("midrst_configout", configout_n, 1'b1);
    reset_n = 1'b1;
    idle();
    tick();

    // Randomized configuration and accesses against the reference decode.
    for (int r = 0; r < 4; r++) begin
      int b0, b1;
      do_reset();
      b0 = 2 * int'($urandom_range(0, 7));
      b1 = 2 * int'($urandom_range(0, 7));
      cfg_write(6'h25, 4'h0, 1);
      cfg_write(6'h24, 4'(b0), 1);
      cfg_write(6'h25, 4'h0, 1);
      cfg_write(6'h24, 4'(b1), 1);
      chk($sformatf("rnd%0d_configured", r), configured, 2'b11);
      for (int k = 0; k < 30; k++) begin
        int sel, a_hi;
        logic u, l;
        logic [1:0] hit, exp_ce;
        sel = int'($urandom_range(0, 2));
        if (sel == 0) a_hi = int'($urandom_range(0, 255));
        else if (sel == 1) a_hi = (b0 << 4) + int'($urandom_range(0, 31));
        else a_hi = (b1 << 4) + int'($urandom_range(0, 31));
        u = 1'($urandom_range(0, 1));
        l = 1'($urandom_range(0, 1));
        hit = model_sel(a_hi, b0, b1);
        exp_ce = (u && l) ? 2'b00 : hit;
        ram_access(8'(a_hi), u, l, exp_ce, (hit != 2'b00), $sformatf("rnd%0d_%0d", r, k));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
